// File: rtl/spi_stream_engine_if.sv
// FIFO handshakes and SPI pins of the SPI stream engine.
// The master modport is the engine side and the slave modport is the FIFO/device side.
interface spi_stream_engine_if #(
  parameter int WIDTH = 8
);
  logic             tx_pop;
  logic [WIDTH-1:0] tx_data;
  logic             tx_nempty;
  logic             rx_shift;
  logic [WIDTH-1:0] rx_data;
  logic             rx_full;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             cs_n;

  modport master (
    output tx_pop,
    input  tx_data,
    input  tx_nempty,
    output rx_shift,
    output rx_data,
    input  rx_full,
    output sclk,
    output mosi,
    input  miso,
    output cs_n
  );

  modport slave (
    input  tx_pop,
    output tx_data,
    output tx_nempty,
    input  rx_shift,
    input  rx_data,
    output rx_full,
    input  sclk,
    input  mosi,
    output miso,
    input  cs_n
  );
endinterface

// File: rtl/spi_stream_engine.sv
// SPI mode-0 master between a TX byte FIFO and an RX byte FIFO.
// Words are shifted MSB-first, and chip select is held across back-to-back words.
module spi_stream_engine #(
  parameter int WIDTH    = 8,
  parameter int DIV_BITS = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] clkdiv,
  output logic                busy,
  spi_stream_engine_if.master sif
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HIGH  = 3'd4,
    ST_STORE = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0]    rx_sr_q, rx_sr_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [DIV_BITS-1:0] reload_q, reload_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                tx_pop_q, tx_pop_d;
  logic                busy_q, busy_d;

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    div_d    = div_q;
    reload_d = reload_q;
    bit_d    = bit_q;
    mosi_d   = mosi_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && sif.tx_nempty) state_d = ST_POP;
        else                         state_d = ST_IDLE;
      end
      ST_POP: state_d = ST_LOAD;
      ST_LOAD: begin
        tx_sr_d  = sif.tx_data;
        reload_d = clkdiv;
        div_d    = clkdiv;
        bit_d    = CNT_W'(WIDTH - 1);
        mosi_d   = sif.tx_data[WIDTH-1];
        state_d  = ST_LOW;
      end
      ST_LOW: begin
        if (div_q == '0) begin
          // The DUT samples MISO on the same edge where SCLK rises.
          rx_sr_d = {rx_sr_q[WIDTH-2:0], sif.miso};
          div_d   = reload_q;
          state_d = ST_HIGH;
        end else begin
          div_d = div_q - DIV_BITS'(1);
        end
      end
      ST_HIGH: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_BITS'(1);
        end else if (bit_q == '0) begin
          state_d = ST_STORE;
        end else begin
          div_d   = reload_q;
          bit_d   = bit_q - CNT_W'(1);
          tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
          mosi_d  = tx_sr_q[WIDTH-2];
          state_d = ST_LOW;
        end
      end
      ST_STORE: begin
        if (sif.rx_full)                  state_d = ST_STORE;
        else if (enable && sif.tx_nempty) state_d = ST_POP;
        else                              state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin outputs are registered from the upcoming state so that they line up with it.
    sclk_d   = (state_d == ST_HIGH);
    tx_pop_d = (state_d == ST_POP);
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE: cs_n_d = 1'b1;
      ST_POP:  cs_n_d = cs_n_q;
      default: cs_n_d = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      div_q    <= '0;
      reload_q <= '0;
      bit_q    <= '0;
      mosi_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      tx_pop_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      div_q    <= div_d;
      reload_q <= reload_d;
      bit_q    <= bit_d;
      mosi_q   <= mosi_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      tx_pop_q <= tx_pop_d;
      busy_q   <= busy_d;
    end
  end

  // The push strobe must follow rx_full within the same cycle, so it is decoded directly.
  assign sif.rx_shift = (state_q == ST_STORE) && !sif.rx_full;
  assign sif.rx_data  = rx_sr_q;
  assign sif.tx_pop   = tx_pop_q;
  assign sif.sclk     = sclk_q;
  assign sif.mosi     = mosi_q;
  assign sif.cs_n     = cs_n_q;
  assign busy         = busy_q;
endmodule
